// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the N-master to 1-slave AXI-lite arbiter.
package axi_lite_arbiter_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;
  localparam logic [2:0] RESP_DECERR = 3'b011;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_ADDR = 2'b01,
    R_DATA = 2'b10
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_ADDR = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

endpackage

// File: rtl/axi_lite_arbiter_rr_picker.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// starting one past the last completed grant.
module axi_lite_arbiter_rr_picker
  import axi_lite_arbiter_pkg::*;
#(
  parameter int NUM_MASTER = 2,
  parameter int ARB_MODE   = ARB_RR,
  localparam int IW        = $clog2(NUM_MASTER)
) (
  input  logic [NUM_MASTER-1:0] req,
  input  logic [IW-1:0]         last_grant,
  output logic [NUM_MASTER-1:0] grant_oh,
  output logic [IW-1:0]         grant_idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan candidates in priority order and keep the first requester.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < NUM_MASTER; off++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = IW'(off);
      end else begin
        cand = IW'((int'(last_grant) + off + 1) % NUM_MASTER);
      end
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// N-master to 1-slave AXI-lite arbiter with independent read and write
// ownership; a grant is held from request until the response handshake.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int NUM_MASTER   = 2,
  parameter int DATA_LEN     = 32,
  parameter int DATA_BIT_NUM = DATA_LEN / 8,
  parameter int ARB_MODE     = ARB_RR
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_MASTER-1:0]               m_arvalid,
  output logic [NUM_MASTER-1:0]               m_arready,
  input  logic [NUM_MASTER*DATA_LEN-1:0]      m_raddr,
  output logic [NUM_MASTER-1:0]               m_rvalid,
  input  logic [NUM_MASTER-1:0]               m_rready,
  output logic [DATA_LEN-1:0]                 m_rdata,
  output logic [2:0]                          m_rresp,
  input  logic [NUM_MASTER-1:0]               m_awvalid,
  output logic [NUM_MASTER-1:0]               m_awready,
  input  logic [NUM_MASTER*DATA_LEN-1:0]      m_waddr,
  input  logic [NUM_MASTER-1:0]               m_wvalid,
  output logic [NUM_MASTER-1:0]               m_wready,
  input  logic [NUM_MASTER*DATA_LEN-1:0]      m_wdata,
  input  logic [NUM_MASTER*DATA_BIT_NUM-1:0]  m_wstrob,
  output logic [NUM_MASTER-1:0]               m_bvalid,
  input  logic [NUM_MASTER-1:0]               m_bready,
  output logic [2:0]                          m_bresp,
  output logic                                s_arvalid,
  input  logic                                s_arready,
  output logic [DATA_LEN-1:0]                 s_raddr,
  input  logic                                s_rvalid,
  output logic                                s_rready,
  input  logic [DATA_LEN-1:0]                 s_rdata,
  input  logic [2:0]                          s_rresp,
  output logic                                s_awvalid,
  input  logic                                s_awready,
  output logic [DATA_LEN-1:0]                 s_waddr,
  output logic                                s_wvalid,
  input  logic                                s_wready,
  output logic [DATA_LEN-1:0]                 s_wdata,
  output logic [DATA_BIT_NUM-1:0]             s_wstrob,
  input  logic                                s_bvalid,
  output logic                                s_bready,
  input  logic [2:0]                          s_bresp,
  output logic                                rd_busy,
  output logic                                wr_busy,
  output logic [$clog2(NUM_MASTER)-1:0]       rd_grant,
  output logic [$clog2(NUM_MASTER)-1:0]       wr_grant
);

  localparam int IW = $clog2(NUM_MASTER);

  rd_state_e     rd_state_q, rd_state_d;
  wr_state_e     wr_state_q, wr_state_d;
  logic [IW-1:0] rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
  logic          aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [NUM_MASTER-1:0] rd_pick_oh, wr_pick_oh, wr_req;
  logic [IW-1:0]         rd_pick_idx, wr_pick_idx;

  logic [DATA_LEN-1:0]     raddr_arr [NUM_MASTER];
  logic [DATA_LEN-1:0]     waddr_arr [NUM_MASTER];
  logic [DATA_LEN-1:0]     wdata_arr [NUM_MASTER];
  logic [DATA_BIT_NUM-1:0] wstrb_arr [NUM_MASTER];

  for (genvar i = 0; i < NUM_MASTER; i++) begin : g_unpack
    assign raddr_arr[i] = m_raddr[i*DATA_LEN +: DATA_LEN];
    assign waddr_arr[i] = m_waddr[i*DATA_LEN +: DATA_LEN];
    assign wdata_arr[i] = m_wdata[i*DATA_LEN +: DATA_LEN];
    assign wstrb_arr[i] = m_wstrob[i*DATA_BIT_NUM +: DATA_BIT_NUM];
  end

  // A write request is either half of the AW/W pair; data may lead the address.
  assign wr_req = m_awvalid | m_wvalid;

  axi_lite_arbiter_rr_picker #(.NUM_MASTER(NUM_MASTER), .ARB_MODE(ARB_MODE)) u_rd_pick (
    .req(m_arvalid), .last_grant(rd_ptr_q), .grant_oh(rd_pick_oh), .grant_idx(rd_pick_idx)
  );

  axi_lite_arbiter_rr_picker #(.NUM_MASTER(NUM_MASTER), .ARB_MODE(ARB_MODE)) u_wr_pick (
    .req(wr_req), .last_grant(wr_ptr_q), .grant_oh(wr_pick_oh), .grant_idx(wr_pick_idx)
  );

  assign rd_busy  = (rd_state_q != R_IDLE);
  assign wr_busy  = (wr_state_q != W_IDLE);
  assign rd_grant = rd_grant_q;
  assign wr_grant = wr_grant_q;
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_bresp  = s_bresp;

  // Read FSM next state and routing of the owning master to the slave.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    m_arready  = '0;
    m_rvalid   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_raddr    = raddr_arr[rd_grant_q];
    case (rd_state_q)
      R_IDLE: begin
        if (|m_arvalid) begin
          rd_grant_d = rd_pick_idx;
          rd_state_d = R_ADDR;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_ADDR: begin
        s_arvalid             = m_arvalid[rd_grant_q];
        m_arready[rd_grant_q] = s_arready;
        if (m_arvalid[rd_grant_q] && s_arready) begin
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_ADDR;
        end
      end
      R_DATA: begin
        m_rvalid[rd_grant_q] = s_rvalid;
        s_rready             = m_rready[rd_grant_q];
        if (s_rvalid && m_rready[rd_grant_q]) begin
          rd_state_d = R_IDLE;
          rd_ptr_d   = rd_grant_q;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM; AW and W complete independently and the done flags mask a
  // channel once it has handshaken so the slave sees each beat exactly once.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    m_awready  = '0;
    m_wready   = '0;
    m_bvalid   = '0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    s_waddr    = waddr_arr[wr_grant_q];
    s_wdata    = wdata_arr[wr_grant_q];
    s_wstrob   = wstrb_arr[wr_grant_q];
    case (wr_state_q)
      W_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (|wr_req) begin
          wr_grant_d = wr_pick_idx;
          wr_state_d = W_ADDR;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_ADDR: begin
        s_awvalid             = m_awvalid[wr_grant_q] & ~aw_done_q;
        m_awready[wr_grant_q] = s_awready & ~aw_done_q;
        s_wvalid              = m_wvalid[wr_grant_q] & ~w_done_q;
        m_wready[wr_grant_q]  = s_wready & ~w_done_q;
        aw_done_d = aw_done_q | (m_awvalid[wr_grant_q] & s_awready);
        w_done_d  = w_done_q  | (m_wvalid[wr_grant_q] & s_wready);
        if (aw_done_d && w_done_d) begin
          wr_state_d = W_RESP;
        end else begin
          wr_state_d = W_ADDR;
        end
      end
      W_RESP: begin
        m_bvalid[wr_grant_q] = s_bvalid;
        s_bready             = m_bready[wr_grant_q];
        if (s_bvalid && m_bready[wr_grant_q]) begin
          wr_state_d = W_IDLE;
          wr_ptr_d   = wr_grant_q;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_grant_q <= '0;
      wr_grant_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_grant_q <= rd_grant_d;
      wr_grant_q <= wr_grant_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench: tests push expected responses, a negedge monitor and a
// slave model pop and compare them as the arbiter presents traffic.
module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  logic clk, rst_n;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0] m_raddr, m_waddr, m_wdata;
  logic [31:0] m_rdata;
  logic [2:0]  m_rresp, m_bresp;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [7:0]  m_wstrob;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_raddr, s_rdata, s_waddr, s_wdata;
  logic [2:0]  s_rresp, s_bresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [3:0]  s_wstrob;
  logic        rd_busy, wr_busy;
  logic [0:0]  rd_grant, wr_grant;

  // second instance in fixed-priority mode, read channel only exercised
  logic        fix_en;
  logic [1:0]  f_arready, f_rvalid, f_awready, f_wready, f_bvalid;
  logic [31:0] f_rdata, f_raddr, f_waddr, f_wdata;
  logic [2:0]  f_rresp, f_bresp;
  logic        f_arvalid, f_rready, f_awvalid, f_wvalid, f_bready, f_rd_busy, f_wr_busy;
  logic [3:0]  f_wstrob;
  logic [0:0]  f_rd_grant, f_wr_grant;

  typedef struct {int master; logic [31:0] data; logic [2:0] resp;} rd_exp_t;
  typedef struct {int master; logic [2:0] resp;} b_exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} ws_exp_t;
  rd_exp_t rd_exp[$];
  b_exp_t  b_exp[$];
  ws_exp_t ws_exp[$];

  int n_tests = 0, n_fail = 0;
  int aw_cnt = 0, w_cnt = 0;

  axi_lite_arbiter #(.NUM_MASTER(2), .DATA_LEN(32), .DATA_BIT_NUM(4), .ARB_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_raddr(m_raddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_waddr(m_waddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrob(m_wstrob),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_raddr(s_raddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_waddr(s_waddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrob(s_wstrob),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .rd_busy(rd_busy), .wr_busy(wr_busy), .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  axi_lite_arbiter #(.NUM_MASTER(2), .DATA_LEN(32), .DATA_BIT_NUM(4), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid({2{fix_en}}), .m_arready(f_arready), .m_raddr(64'h0000_0010_0000_0020),
    .m_rvalid(f_rvalid), .m_rready(2'b11), .m_rdata(f_rdata), .m_rresp(f_rresp),
    .m_awvalid(2'b00), .m_awready(f_awready), .m_waddr(64'h0),
    .m_wvalid(2'b00), .m_wready(f_wready), .m_wdata(64'h0), .m_wstrob(8'h00),
    .m_bvalid(f_bvalid), .m_bready(2'b00), .m_bresp(f_bresp),
    .s_arvalid(f_arvalid), .s_arready(1'b1), .s_raddr(f_raddr),
    .s_rvalid(1'b1), .s_rready(f_rready), .s_rdata(32'h0), .s_rresp(3'b000),
    .s_awvalid(f_awvalid), .s_awready(1'b0), .s_waddr(f_waddr),
    .s_wvalid(f_wvalid), .s_wready(1'b0), .s_wdata(f_wdata), .s_wstrob(f_wstrob),
    .s_bvalid(1'b0), .s_bready(f_bready), .s_bresp(3'b000),
    .rd_busy(f_rd_busy), .wr_busy(f_wr_busy), .rd_grant(f_rd_grant), .wr_grant(f_wr_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Slave model: read data = addr ^ 0x80000413, SLVERR for the 0xF region.
  initial begin
    logic rst_smp, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got;
    logic [31:0] ar_addr, aw_addr, w_data, sv_addr, sv_data;
    logic [3:0]  w_strb, sv_strb;
    ws_exp_t     e;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 3'b000;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = 3'b000;
    aw_got = 1'b0; w_got = 1'b0;
    sv_addr = 32'h0; sv_data = 32'h0; sv_strb = 4'h0;
    forever begin
      @(negedge clk);
      rst_smp = rst_n;
      ar_hs = s_arvalid && s_arready; ar_addr = s_raddr;
      r_hs  = s_rvalid && s_rready;
      aw_hs = s_awvalid && s_awready; aw_addr = s_waddr;
      w_hs  = s_wvalid && s_wready; w_data = s_wdata; w_strb = s_wstrob;
      b_hs  = s_bvalid && s_bready;
      @(posedge clk); #1;
      if (!rst_smp) begin
        s_rvalid = 1'b0; s_bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        if (r_hs) s_rvalid = 1'b0;
        if (ar_hs) begin
          s_rvalid = 1'b1;
          s_rdata  = ar_addr ^ 32'h8000_0413;
          s_rresp  = (ar_addr[31:28] == 4'hF) ? RESP_SLVERR : RESP_OKAY;
        end
        if (aw_hs) begin aw_got = 1'b1; sv_addr = aw_addr; aw_cnt++; end
        if (w_hs) begin w_got = 1'b1; sv_data = w_data; sv_strb = w_strb; w_cnt++; end
        if (b_hs) s_bvalid = 1'b0;
        if (aw_got && w_got) begin
          if (ws_exp.size() == 0) begin
            fail_msg("slave_write_unexpected");
          end else begin
            e = ws_exp.pop_front();
            check("slave_waddr", {32'h0, sv_addr}, {32'h0, e.addr});
            check("slave_wdata", {32'h0, sv_data}, {32'h0, e.data});
            check("slave_wstrb", {60'h0, sv_strb}, {60'h0, e.strb});
          end
          s_bvalid = 1'b1;
          s_bresp  = (sv_addr[31:28] == 4'hF) ? RESP_SLVERR : RESP_OKAY;
          aw_got = 1'b0; w_got = 1'b0;
        end
      end
    end
  end

  // Monitor: master-side responses against the expected queues.
  initial begin
    rd_exp_t r;
    b_exp_t  b;
    logic [1:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_rvalid != 2'b00) begin
          if (rd_exp.size() == 0) begin
            fail_msg("rvalid_unexpected");
          end else begin
            r = rd_exp[0];
            oh = 2'b01 << r.master;
            check("m_rvalid_owner", {62'h0, m_rvalid}, {62'h0, oh});
            if ((m_rvalid & m_rready) != 2'b00) begin
              r = rd_exp.pop_front();
              check("m_rdata", {32'h0, m_rdata}, {32'h0, r.data});
              check("m_rresp", {61'h0, m_rresp}, {61'h0, r.resp});
            end
          end
        end
        if (m_bvalid != 2'b00) begin
          if (b_exp.size() == 0) begin
            fail_msg("bvalid_unexpected");
          end else begin
            b = b_exp[0];
            oh = 2'b01 << b.master;
            check("m_bvalid_owner", {62'h0, m_bvalid}, {62'h0, oh});
            if ((m_bvalid & m_bready) != 2'b00) begin
              b = b_exp.pop_front();
              check("m_bresp", {61'h0, m_bresp}, {61'h0, b.resp});
            end
          end
        end
      end
    end
  end

  task automatic do_read(input int m, input logic [31:0] addr, input int rdelay);
    bit done = 1'b0;
    int c = 0, held = 0;
    logic ar, rv, rh;
    m_raddr[m*32 +: 32] = addr;
    m_arvalid[m] = 1'b1;
    if (rdelay == 0) m_rready[m] = 1'b1;
    while (!done && c < 100) begin
      @(negedge clk);
      ar = m_arvalid[m] && m_arready[m];
      rv = m_rvalid[m];
      rh = rv && m_rready[m];
      @(posedge clk); #1;
      c++;
      if (ar) m_arvalid[m] = 1'b0;
      if (rh) begin
        m_rready[m] = 1'b0;
        done = 1'b1;
      end else if (rv) begin
        held++;
        if (held >= rdelay) m_rready[m] = 1'b1;
      end
    end
    if (!done) fail_msg($sformatf("read_timeout_m%0d", m));
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_delay);
    bit done = 1'b0, aw_dn = 1'b0;
    int c = 0;
    logic aw, w, bh;
    m_waddr[m*32 +: 32] = addr;
    m_wdata[m*32 +: 32] = data;
    m_wstrob[m*4 +: 4]  = strb;
    m_bready[m] = 1'b1;
    m_wvalid[m] = 1'b1;
    if (aw_delay == 0) m_awvalid[m] = 1'b1;
    while (!done && c < 100) begin
      @(negedge clk);
      aw = m_awvalid[m] && m_awready[m];
      w  = m_wvalid[m] && m_wready[m];
      bh = m_bvalid[m] && m_bready[m];
      @(posedge clk); #1;
      c++;
      if (aw) begin m_awvalid[m] = 1'b0; aw_dn = 1'b1; end
      if (w) m_wvalid[m] = 1'b0;
      if (bh) begin m_bready[m] = 1'b0; done = 1'b1; end
      if (c == aw_delay && !aw_dn) m_awvalid[m] = 1'b1;
    end
    if (!done) fail_msg($sformatf("write_timeout_m%0d", m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int aw_snap, w_snap, nseen;
    logic m1_seen;
    bit found;
    rst_n = 1'b0; fix_en = 1'b0;
    m_arvalid = '0; m_rready = '0; m_raddr = '0;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0;
    m_waddr = '0; m_wdata = '0; m_wstrob = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_handshakes", {54'h0, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
          m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 64'h0);
    check("reset_busy_grant", {60'h0, rd_busy, wr_busy, rd_grant, wr_grant}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single read from M0 with one-cycle grant latency
    rd_exp.push_back('{master: 0, data: 32'h0000_0413, resp: RESP_OKAY});
    m1_seen = 1'b0;
    fork
      do_read(0, 32'h8000_0000, 0);
      begin
        @(negedge clk);
        check("single_arvalid_idle", {63'h0, s_arvalid}, 64'h0);
        @(negedge clk);
        check("single_arvalid_granted", {63'h0, s_arvalid}, 64'h1);
        check("single_raddr", {32'h0, s_raddr}, 64'h8000_0000);
        check("single_arready", {62'h0, m_arready}, 64'h1);
        repeat (4) begin
          @(negedge clk);
          m1_seen = m1_seen | m_arready[1] | m_rvalid[1];
        end
        check("single_m1_quiet", {63'h0, m1_seen}, 64'h0);
      end
    join

    // M1 read of the error region; leaves the read pointer at M1
    rd_exp.push_back('{master: 1, data: 32'h7000_0413, resp: RESP_SLVERR});
    do_read(1, 32'hF000_0000, 0);

    // round-robin contention: expected order 0,1,0,1
    rd_exp.push_back('{master: 0, data: 32'h0000_0417, resp: RESP_OKAY});
    rd_exp.push_back('{master: 1, data: 32'h0000_041B, resp: RESP_OKAY});
    rd_exp.push_back('{master: 0, data: 32'h0000_041F, resp: RESP_OKAY});
    rd_exp.push_back('{master: 1, data: 32'h0000_0403, resp: RESP_OKAY});
    fork
      begin do_read(0, 32'h8000_0004, 0); do_read(0, 32'h8000_000C, 0); end
      begin do_read(1, 32'h8000_0008, 0); do_read(1, 32'h8000_0010, 0); end
    join
    check("rr_queue_drained", {32'h0, 32'(rd_exp.size())}, 64'h0);

    // fixed priority: M0 keeps winning while both request
    @(posedge clk); #1;
    fix_en = 1'b1;
    nseen = 0;
    for (int i = 0; i < 40 && nseen < 3; i++) begin
      @(negedge clk);
      if (f_arvalid) begin
        check($sformatf("fixed_grant_%0d", nseen), {63'h0, f_rd_grant}, 64'h0);
        nseen++;
      end
    end
    if (nseen < 3) fail_msg("fixed_grant_count");
    @(posedge clk); #1;
    fix_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // concurrent M0 read and M1 write
    rd_exp.push_back('{master: 0, data: 32'h0000_0413, resp: RESP_OKAY});
    ws_exp.push_back('{addr: 32'h8000_2000, data: 32'h1234_5678, strb: 4'hF});
    b_exp.push_back('{master: 1, resp: RESP_OKAY});
    fork
      do_read(0, 32'h8000_0000, 0);
      do_write(1, 32'h8000_2000, 32'h1234_5678, 4'hF, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("concurrent_grants", {62'h0, rd_grant, wr_grant}, 64'h1);
        check("concurrent_valids", {61'h0, s_arvalid, s_awvalid, s_wvalid}, 64'h7);
      end
    join

    // write data before address from M1
    aw_snap = aw_cnt; w_snap = w_cnt;
    ws_exp.push_back('{addr: 32'h8000_1000, data: 32'hDEAD_BEEF, strb: 4'b0011});
    b_exp.push_back('{master: 1, resp: RESP_OKAY});
    do_write(1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 3);
    @(negedge clk);
    check("write_aw_handshakes", {32'h0, 32'(aw_cnt - aw_snap)}, 64'h1);
    check("write_w_handshakes", {32'h0, 32'(w_cnt - w_snap)}, 64'h1);
    check("write_idle_after", {63'h0, wr_busy}, 64'h0);
    check("write_queues_drained", {32'h0, 32'(ws_exp.size() + b_exp.size())}, 64'h0);

    // master backpressure on the read data channel
    @(posedge clk); #1;
    rd_exp.push_back('{master: 0, data: 32'h0000_041B, resp: RESP_OKAY});
    fork
      do_read(0, 32'h8000_0008, 3);
      begin
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
          @(negedge clk);
          found = m_rvalid[0];
        end
        if (!found) fail_msg("bp_rvalid_wait");
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check($sformatf("bp_rready_low_%0d", k), {63'h0, s_rready}, 64'h0);
          check($sformatf("bp_grant_%0d", k), {62'h0, rd_busy, rd_grant}, 64'h2);
          check($sformatf("bp_rdata_%0d", k), {32'h0, m_rdata}, 64'h0000_041B);
        end
        @(negedge clk);
        check("bp_rready_high", {63'h0, s_rready}, 64'h1);
        @(negedge clk);
        check("bp_busy_clear", {63'h0, rd_busy}, 64'h0);
      end
    join

    // reset while M0 sits in the data phase
    @(posedge clk); #1;
    rd_exp.push_back('{master: 0, data: 32'h0000_041B, resp: RESP_OKAY});
    m_raddr[31:0] = 32'h8000_0008;
    m_arvalid[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = m_arready[0];
    end
    if (!found) fail_msg("rst_arready_wait");
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = m_rvalid[0];
    end
    if (!found) fail_msg("rst_rvalid_wait");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rd_exp.delete();
    @(negedge clk);
    check("midrst_handshakes", {54'h0, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
          m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 64'h0);
    check("midrst_busy_grant", {62'h0, rd_busy, rd_grant}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_exp.push_back('{master: 1, data: 32'h0000_0413, resp: RESP_OKAY});
    rd_exp.push_back('{master: 0, data: 32'h0000_0417, resp: RESP_OKAY});
    fork
      do_read(1, 32'h8000_0000, 0);
      do_read(0, 32'h8000_0004, 0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("post_rst_first_grant", {62'h0, rd_busy, rd_grant}, 64'h3);
      end
    join
    check("final_queue_drained", {32'h0, 32'(rd_exp.size())}, 64'h0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
